mul_ctrl: RTL and testbench
===========================

Name: mul_ctrl

Overview:
- Sequencing controller for the pipelined 64x64 Booth/CSA multiplier datapath (partial-product generation, 4:2 compression, final add).
- Accepts one RV64M multiply request at a time from EX and drives operands, sign controls and the 2-bit hold flag into the datapath.
- Tracks the in-flight operation, selects and formats the 64-bit result, and holds EX until the response is consumed.
- Handles pipeline flush and a missing-completion watchdog.

Parameters:
- DATA_W, 64, operand/result width
- MUL_LAT, 3, nominal cycles from MulStart to MulDone
- WDOG_CYC, 15, WAIT/DRAIN cycles without MulDone before abort; must exceed MUL_LAT

Ports:
- Clk  in  1  clock
- Rst  in  1  synchronous active-low reset
- ReqValid  in  1  EX presents a multiply
- ReqReady  out  1  controller can accept
- ReqOp  in  2  0=MUL, 1=MULH, 2=MULHSU, 3=MULHU
- ReqWord  in  1  MULW (valid only with ReqOp=0)
- ReqA  in  DATA_W  rs1
- ReqB  in  DATA_W  rs2
- Flush  in  1  kill current operation
- MulStart  out  1  one-cycle launch pulse to datapath
- MulA  out  DATA_W  multiplicand to datapath
- MulB  out  DATA_W  multiplier to datapath
- MulSignA  out  1  treat MulA as signed
- MulSignB  out  1  treat MulB as signed
- MulHoldFlag  out  2  hold flag to datapath
- MulDone  in  1  datapath completion pulse
- MulProd  in  2*DATA_W  full product, valid with MulDone
- RespValid  out  1  result available
- RespReady  in  1  EX consumes result
- RespData  out  DATA_W  formatted result
- MulHoldToEx  out  1  stall EX (state != IDLE)
- MulErr  out  1  sticky watchdog error flag

Behaviour:
- Reset (Rst=0 at posedge): state IDLE; all outputs 0 except ReqReady=1; operand registers, counter and MulErr cleared. Reset mid-operation abandons it; a later MulDone is ignored in IDLE.
- States and transitions:
  - IDLE: ReqReady=1. On ReqValid&!Flush, latch op/operands and go to ISSUE.
  - ISSUE (1 cycle): MulStart=1, MulHoldFlag=01, counter cleared. Go to WAIT. If Flush, suppress MulStart and go to IDLE.
  - WAIT: MulHoldFlag=10; counter increments each cycle. On MulDone, capture formatted result and go to DONE. When counter reaches WDOG_CYC, set MulErr, force RespData=0 and go to DONE. Flush goes to DRAIN.
  - DONE: RespValid=1; RespData stable until RespReady, then go to IDLE (no same-cycle re-accept). Flush goes to IDLE with RespValid dropped.
  - DRAIN: ReqReady=0; wait for MulDone (discarded) or watchdog (MulErr not set), then go to IDLE.
- Flush has priority over every other event in the same cycle.
- MulDone outside WAIT/DRAIN is ignored.
- Operand and sign control:
  - MUL: SignA=1, SignB=1.
  - MULH: SignA=1, SignB=1.
  - MULHSU: SignA=1, SignB=0.
  - MULHU: SignA=0, SignB=0.
  - MULW: MulA/MulB = sign-extended low 32 bits of ReqA/ReqB, both signed.
  - MulA/MulB/Sign* held constant from ISSUE through WAIT.
- Result select:
  - MUL: MulProd[63:0].
  - MULH/MULHSU/MULHU: MulProd[127:64].
  - MULW: sign-extend MulProd[31:0].
- Latency with no stalls: accept at cycle 0, MulStart at cycle 1, MulDone at cycle 1+MUL_LAT, RespValid the next cycle. Total 2+MUL_LAT cycles to response.
- MulErr is sticky and cleared only by reset.

Optional Feature:
- MUL_PROD_REUSE_EN. When defined, the controller keeps the last full 128-bit product with its operands and sign mode; the cache is invalidated by reset, flush or watchdog.
- With the feature: a request with matching ReqA, ReqB, sign mode and ReqWord goes from IDLE straight to DONE. No MulStart is issued, and RespValid appears one cycle after accept. Example: MULH then MUL on the same pair.
- Without the feature: every request takes the full ISSUE/WAIT path.

Test Plan:
- MUL 0x3 x 0xFFFFFFFFFFFFFFFF (-1), MulDone at MUL_LAT -> RespData=0xFFFFFFFFFFFFFFFD, RespValid at cycle 5, MulStart exactly once.
- MULHU 0xFFFFFFFFFFFFFFFF x 2 -> SignA=SignB=0, RespData=0x1. MULHSU -1 x 2 -> SignA=1, SignB=0, RespData=0xFFFFFFFFFFFFFFFF.
- MULW A=0x00000000_80000000, B=2 -> MulA=0xFFFFFFFF80000000, RespData=0x0000000000000000. A=0x40000000, B=2 -> RespData=0xFFFFFFFF80000000.
- Flush in WAIT, then ReqValid held -> ReqReady=0 until the stale MulDone arrives, that product is not returned, and the new request completes with its own value.
- MulDone never asserted -> after WDOG_CYC WAIT cycles MulErr=1, RespValid=1, RespData=0; MulErr stays 1 after the next good op.
- RespReady held low 10 cycles in DONE -> RespValid and RespData stable, MulHoldToEx=1, ReqReady=0. Rst=0 in WAIT -> all outputs at reset values next cycle.

Source files
------------

// File: rtl/mul_ctrl.sv
// Sequencing controller for the pipelined 64x64 Booth/CSA multiplier datapath.
// Optional product-reuse cache enabled by defining MUL_PROD_REUSE_EN.
module mul_ctrl #(
  parameter int DATA_W   = 64,
  parameter int MUL_LAT  = 3,
  parameter int WDOG_CYC = 15
) (
  input  logic                Clk,
  input  logic                Rst,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [1:0]          ReqOp,
  input  logic                ReqWord,
  input  logic [DATA_W-1:0]   ReqA,
  input  logic [DATA_W-1:0]   ReqB,
  input  logic                Flush,
  output logic                MulStart,
  output logic [DATA_W-1:0]   MulA,
  output logic [DATA_W-1:0]   MulB,
  output logic                MulSignA,
  output logic                MulSignB,
  output logic [1:0]          MulHoldFlag,
  input  logic                MulDone,
  input  logic [2*DATA_W-1:0] MulProd,
  output logic                RespValid,
  input  logic                RespReady,
  output logic [DATA_W-1:0]   RespData,
  output logic                MulHoldToEx,
  output logic                MulErr
);

  // state | meaning
  // IDLE  | ready for a request
  // ISSUE | launch pulse to datapath
  // WAIT  | product in flight, watchdog running
  // DONE  | result presented, EX held until consumed
  // DRAIN | flushed op still in datapath, waiting for its completion
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DONE, DRAIN} state_t;

  localparam int CW = $clog2(WDOG_CYC + 1);

  generate
    if (WDOG_CYC <= MUL_LAT) begin : gBadWdog
      $error("WDOG_CYC must exceed MUL_LAT");
    end
  endgenerate

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [1:0]        opQ;
  logic              wordQ;
  logic              startQ;
  logic              reqWord;
  logic [DATA_W-1:0] reqAFmt;
  logic [DATA_W-1:0] reqBFmt;
  logic              reqSignA;
  logic              reqSignB;
  logic              wdogHit;
  logic              reuseHit;
  logic [DATA_W-1:0] reuseData;

  function automatic logic [DATA_W-1:0] fmtResult(input logic [2*DATA_W-1:0] p,
                                                  input logic [1:0] op, input logic w);
    if (w)              fmtResult = {{(DATA_W-32){p[31]}}, p[31:0]};
    else if (op == 2'd0) fmtResult = p[DATA_W-1:0];
    else                fmtResult = p[2*DATA_W-1:DATA_W];
  endfunction

  // MULW only exists for op 0; word operands are sign-extended and both signed.
  always_comb begin
    reqWord  = ReqWord && (ReqOp == 2'd0);
    reqAFmt  = reqWord ? {{(DATA_W-32){ReqA[31]}}, ReqA[31:0]} : ReqA;
    reqBFmt  = reqWord ? {{(DATA_W-32){ReqB[31]}}, ReqB[31:0]} : ReqB;
    reqSignA = reqWord || (ReqOp != 2'd3);
    reqSignB = reqWord || (ReqOp[1] == 1'b0);
  end

  // Compare with >= so a flush on the last WAIT cycle still terminates DRAIN.
  assign wdogHit  = (cnt >= CW'(WDOG_CYC - 1));
  assign MulStart = startQ && !Flush;

`ifdef MUL_PROD_REUSE_EN
  logic                cacheVld;
  logic [2*DATA_W-1:0] cacheProd;
  logic [DATA_W-1:0]   cacheA;
  logic [DATA_W-1:0]   cacheB;
  logic                cacheSignA;
  logic                cacheSignB;
  logic                cacheWord;

  always_ff @(posedge Clk) begin
    if (!Rst || Flush) begin
      cacheVld <= 1'b0;
    end else if (state == WAIT && MulDone) begin
      cacheVld   <= 1'b1;
      cacheProd  <= MulProd;
      cacheA     <= MulA;
      cacheB     <= MulB;
      cacheSignA <= MulSignA;
      cacheSignB <= MulSignB;
      cacheWord  <= wordQ;
    end else if (state == WAIT && wdogHit) begin
      cacheVld <= 1'b0;
    end
  end

  assign reuseHit  = cacheVld && (cacheA == reqAFmt) && (cacheB == reqBFmt) &&
                     (cacheSignA == reqSignA) && (cacheSignB == reqSignB) &&
                     (cacheWord == reqWord);
  assign reuseData = fmtResult(cacheProd, ReqOp, reqWord);
`else
  assign reuseHit  = 1'b0;
  assign reuseData = '0;
`endif

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state       <= IDLE;
      cnt         <= '0;
      opQ         <= '0;
      wordQ       <= 1'b0;
      startQ      <= 1'b0;
      ReqReady    <= 1'b1;
      MulA        <= '0;
      MulB        <= '0;
      MulSignA    <= 1'b0;
      MulSignB    <= 1'b0;
      MulHoldFlag <= 2'b00;
      RespValid   <= 1'b0;
      RespData    <= '0;
      MulHoldToEx <= 1'b0;
      MulErr      <= 1'b0;
    end else begin
      startQ <= 1'b0;
      case (state)
        IDLE: begin
          if (ReqValid && !Flush) begin
            opQ         <= ReqOp;
            wordQ       <= reqWord;
            MulA        <= reqAFmt;
            MulB        <= reqBFmt;
            MulSignA    <= reqSignA;
            MulSignB    <= reqSignB;
            ReqReady    <= 1'b0;
            MulHoldToEx <= 1'b1;
            if (reuseHit) begin
              state     <= DONE;
              RespValid <= 1'b1;
              RespData  <= reuseData;
            end else begin
              state       <= ISSUE;
              startQ      <= 1'b1;
              MulHoldFlag <= 2'b01;
            end
          end
        end
        ISSUE: begin
          cnt <= '0;
          if (Flush) begin
            state       <= IDLE;
            ReqReady    <= 1'b1;
            MulHoldFlag <= 2'b00;
            MulHoldToEx <= 1'b0;
          end else begin
            state       <= WAIT;
            MulHoldFlag <= 2'b10;
          end
        end
        WAIT: begin
          if (Flush) begin
            MulHoldFlag <= 2'b00;
            cnt         <= cnt + CW'(1);
            if (MulDone) begin
              state       <= IDLE;
              ReqReady    <= 1'b1;
              MulHoldToEx <= 1'b0;
            end else begin
              state <= DRAIN;
            end
          end else if (MulDone) begin
            state       <= DONE;
            MulHoldFlag <= 2'b00;
            RespValid   <= 1'b1;
            RespData    <= fmtResult(MulProd, opQ, wordQ);
          end else if (wdogHit) begin
            state       <= DONE;
            MulHoldFlag <= 2'b00;
            RespValid   <= 1'b1;
            RespData    <= '0;
            MulErr      <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (Flush || RespReady) begin
            state       <= IDLE;
            RespValid   <= 1'b0;
            RespData    <= '0;
            ReqReady    <= 1'b1;
            MulHoldToEx <= 1'b0;
          end
        end
        DRAIN: begin
          if (MulDone || wdogHit) begin
            state       <= IDLE;
            ReqReady    <= 1'b1;
            MulHoldToEx <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_ctrl.sv
// Self-checking bench for mul_ctrl: vector table, random ops against an
// arithmetic reference model, and hand-written flush/watchdog/stall/reset sequences.
module tb_mul_ctrl;

  localparam int MUL_LAT  = 3;
  localparam int WDOG_CYC = 15;

  logic         Clk = 0;
  logic         Rst = 0;
  logic         ReqValid = 0;
  logic         ReqReady;
  logic [1:0]   ReqOp = 0;
  logic         ReqWord = 0;
  logic [63:0]  ReqA = 0;
  logic [63:0]  ReqB = 0;
  logic         Flush = 0;
  logic         MulStart;
  logic [63:0]  MulA;
  logic [63:0]  MulB;
  logic         MulSignA;
  logic         MulSignB;
  logic [1:0]   MulHoldFlag;
  logic         MulDone = 0;
  logic [127:0] MulProd = 0;
  logic         RespValid;
  logic         RespReady = 0;
  logic [63:0]  RespData;
  logic         MulHoldToEx;
  logic         MulErr;

  mul_ctrl #(.DATA_W(64), .MUL_LAT(MUL_LAT), .WDOG_CYC(WDOG_CYC)) dut (
    .Clk(Clk), .Rst(Rst), .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqOp(ReqOp),
    .ReqWord(ReqWord), .ReqA(ReqA), .ReqB(ReqB), .Flush(Flush), .MulStart(MulStart),
    .MulA(MulA), .MulB(MulB), .MulSignA(MulSignA), .MulSignB(MulSignB),
    .MulHoldFlag(MulHoldFlag), .MulDone(MulDone), .MulProd(MulProd),
    .RespValid(RespValid), .RespReady(RespReady), .RespData(RespData),
    .MulHoldToEx(MulHoldToEx), .MulErr(MulErr)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  // Datapath stand-in: completes dpLat cycles after the launch pulse.
  int          dpLat = MUL_LAT;
  bit          dpEn = 1;
  int          pend = 0;
  int          startCnt = 0;
  int          doneCnt = 0;
  logic [63:0] dpA = 0, dpB = 0;
  logic        dpSA = 0, dpSB = 0;

  function automatic logic [127:0] prodOf(logic [63:0] a, logic [63:0] b, logic sa, logic sb);
    logic [127:0] ea, eb;
    ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
    eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
    return ea * eb;
  endfunction

  always @(negedge Clk) begin
    MulDone = 0;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && dpEn) begin
        MulDone = 1;
        MulProd = prodOf(dpA, dpB, dpSA, dpSB);
        doneCnt++;
      end
    end
    if (MulStart) begin
      pend = dpLat;
      dpA = MulA; dpB = MulB; dpSA = MulSignA; dpSB = MulSignB;
      startCnt++;
    end
  end

  // Reference result straight from the RV64M definitions.
  function automatic logic [63:0] refMul(logic [1:0] op, logic word, logic [63:0] a, logic [63:0] b);
    logic signed [127:0] sa, sb;
    logic [127:0] ua, ub, p;
    int x, y, p32;
    if (word && op == 2'd0) begin
      x = a[31:0]; y = b[31:0];
      p32 = x * y;
      return 64'(longint'(p32));
    end
    sa = $signed(a); sb = $signed(b);
    ua = {64'd0, a}; ub = {64'd0, b};
    case (op)
      2'd0: p = ua * ub;
      2'd1: p = sa * sb;
      2'd2: p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 2'd0) ? p[63:0] : p[127:64];
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the response is consumed.
  task automatic doOp(input logic [1:0] op, input logic word, input logic [63:0] a,
                      input logic [63:0] b, input logic [63:0] expData, input int expLat,
                      input int holdCyc, input int expStarts, input string name);
    int k, s0, bad;
    logic [63:0] held;
    ReqOp = op; ReqWord = word; ReqA = a; ReqB = b; ReqValid = 1;
    k = 0;
    while (!ReqReady && k < 60) begin @(negedge Clk); k++; end
    chk({name, " accept"}, ReqReady, 1);
    if (!ReqReady) begin ReqValid = 0; return; end
    s0 = startCnt;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 0;
    k = 1;
    while (!RespValid && k < 60) begin @(negedge Clk); k++; end
    chk({name, " respvalid"}, RespValid, 1);
    if (expLat > 0) chk({name, " latency"}, k, expLat);
    chk({name, " data"}, RespData, expData);
    chk({name, " starts"}, startCnt - s0, expStarts);
    held = RespData;
    bad = 0;
    repeat (holdCyc) begin
      @(negedge Clk);
      if (!RespValid || RespData !== held || !MulHoldToEx || ReqReady) bad++;
    end
    if (holdCyc > 0) chk({name, " hold stable"}, bad, 0);
    RespReady = 1;
    @(negedge Clk);
    RespReady = 0;
    chk({name, " released"}, {RespValid, ReqReady, MulHoldToEx}, 3'b010);
  endtask

  typedef struct {
    logic [1:0]  op;
    logic        word;
    logic [63:0] a, b;
    logic [63:0] mulA;
    logic        sA, sB;
    logic [63:0] data;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int k, d0;
    bit sawResp;
    logic [1:0] op;
    logic word;
    logic [63:0] a, b;

    vecs[0] = '{2'd0, 1'b0, 64'h3, 64'hFFFFFFFFFFFFFFFF, 64'h3, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFD};
    vecs[1] = '{2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h2, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 64'h1};
    vecs[2] = '{2'd2, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h2, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFF};
    vecs[3] = '{2'd0, 1'b1, 64'h80000000, 64'h2, 64'hFFFFFFFF80000000, 1'b1, 1'b1, 64'h0};
    vecs[4] = '{2'd0, 1'b1, 64'h40000000, 64'h2, 64'h40000000, 1'b1, 1'b1, 64'hFFFFFFFF80000000};
    vecs[5] = '{2'd1, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b1, 64'h0};
    vecs[6] = '{2'd1, 1'b0, 64'h8000000000000000, 64'h8000000000000000, 64'h8000000000000000, 1'b1, 1'b1, 64'h4000000000000000};
    vecs[7] = '{2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFE};
    vecs[8] = '{2'd0, 1'b1, 64'hDEADBEEF00000003, 64'h12345678FFFFFFFF, 64'h3, 1'b1, 1'b1, 64'hFFFFFFFFFFFFFFFD};
    vecs[9] = '{2'd0, 1'b0, 64'h0, 64'h123, 64'h0, 1'b1, 1'b1, 64'h0};

    repeat (3) @(negedge Clk);
    chk("reset ctl", {ReqReady, MulStart, MulHoldFlag, RespValid, MulHoldToEx, MulErr}, 7'b1000000);
    chk("reset data", RespData, 0);
    chk("reset mula", MulA, 0);
    Rst = 1;
    @(negedge Clk);

    for (int i = 0; i < 10; i++) begin
      doOp(vecs[i].op, vecs[i].word, vecs[i].a, vecs[i].b, vecs[i].data, 2 + MUL_LAT, 0, 1,
           $sformatf("vec%0d", i));
      chk($sformatf("vec%0d mula", i), dpA, vecs[i].mulA);
      chk($sformatf("vec%0d signs", i), {dpSA, dpSB}, {vecs[i].sA, vecs[i].sB});
    end
    chk("no err after vectors", MulErr, 0);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      word = (op == 2'd0) ? 1'($urandom_range(0, 1)) : 1'b0;
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (i % 8 == 1) a[63] = 1'b1;
      doOp(op, word, a, b, refMul(op, word, a, b), 2 + MUL_LAT, $urandom_range(0, 2), 1,
           $sformatf("rand%0d op%0d w%0d", i, op, word));
    end

    // Flush while WAIT: datapath still owes a completion that must be swallowed.
    dpLat = 6;
    ReqOp = 0; ReqWord = 0; ReqA = 64'd11; ReqB = 64'd13; ReqValid = 1;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 0;
    chk("issue pulse", {MulStart, MulHoldFlag}, 3'b101);
    @(negedge Clk);
    chk("wait flag", MulHoldFlag, 2'b10);
    Flush = 1;
    @(negedge Clk);
    Flush = 0;
    dpLat = MUL_LAT;
    chk("drain ready", {ReqReady, MulHoldToEx}, 2'b01);
    d0 = doneCnt;
    ReqA = 64'd21; ReqB = 64'd4; ReqValid = 1;
    k = 0; sawResp = 0;
    while (!ReqReady && k < 40) begin
      @(negedge Clk); k++;
      if (RespValid) sawResp = 1;
    end
    chk("drain stale done", doneCnt - d0, 1);
    chk("drain no stale resp", sawResp, 0);
    doOp(2'd0, 1'b0, 64'd21, 64'd4, 64'd84, 2 + MUL_LAT, 0, 1, "after flush");

    doOp(2'd0, 1'b0, 64'h123456789, 64'h1000, refMul(2'd0, 1'b0, 64'h123456789, 64'h1000),
         2 + MUL_LAT, 10, 1, "resp stall");

    a = 64'h0000000100000003;
    b = 64'hFFFFFFFFFFFFFFFE;
    doOp(2'd1, 1'b0, a, b, refMul(2'd1, 1'b0, a, b), 2 + MUL_LAT, 0, 1, "pair mulh");
`ifdef MUL_PROD_REUSE_EN
    doOp(2'd0, 1'b0, a, b, refMul(2'd0, 1'b0, a, b), 1, 0, 0, "pair mul reuse");
`else
    doOp(2'd0, 1'b0, a, b, refMul(2'd0, 1'b0, a, b), 2 + MUL_LAT, 0, 1, "pair mul");
`endif

    dpEn = 0;
    doOp(2'd0, 1'b0, 64'd7, 64'd9, 64'd0, 2 + WDOG_CYC, 0, 1, "watchdog");
    chk("watchdog err", MulErr, 1);
    dpEn = 1;
    doOp(2'd0, 1'b0, 64'd7, 64'd9, 64'd63, 2 + MUL_LAT, 0, 1, "after watchdog");
    chk("err sticky", MulErr, 1);

    // Reset with an op in WAIT; its late completion must be ignored.
    ReqOp = 0; ReqWord = 0; ReqA = 64'd5; ReqB = 64'd7; ReqValid = 1;
    @(posedge Clk);
    @(negedge Clk);
    ReqValid = 0;
    @(negedge Clk);
    Rst = 0;
    @(negedge Clk);
    Rst = 1;
    chk("rst wait ctl", {ReqReady, MulStart, MulHoldFlag, RespValid, MulHoldToEx, MulErr}, 7'b1000000);
    chk("rst wait data", RespData, 0);
    chk("rst wait ops", {MulA, MulB, MulSignA, MulSignB}, 130'd0);
    k = 0;
    repeat (4) begin
      @(negedge Clk);
      if (RespValid || !ReqReady || MulHoldToEx) k++;
    end
    chk("stale done ignored", k, 0);
    doOp(2'd3, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'h10, 64'hF, 2 + MUL_LAT, 0, 1, "after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
